fsm_step_sequencer_v: RTL and testbench
=======================================

// Module: fsm_step_sequencer_v
// PURPOSE
//  Command-driven sequencer for the shared 2-bit mod-4 up/down phase counter.
//  Accepts move commands (direction + step count) over a valid/ready handshake.
//  Advances the phase once every PERIOD clocks, then pulses done.
//  Sits between the control logic and any phase-driven load (stepper coils, LED ring).
// PARAMETERS
//  STEP_W  8  width of the step-count field and of remaining
//  PERIOD  4  clocks per phase step; legal range 1..2^16-1
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, synchronous, active-low
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       block can accept a command (high only in IDLE)
//  cmd_dir      in   1       0 = count up (+1 mod 4), 1 = count down (-1 mod 4)
//  cmd_steps    in   STEP_W  number of phase steps to perform
//  abort        in   1       stop the current move after the current cycle
//  phase        out  2       current counter phase
//  step_strobe  out  1       high for one cycle; phase changes on the following edge
//  remaining    out  STEP_W  steps still to perform
//  busy         out  1       high in RUN
//  done         out  1       one-cycle pulse when a move finishes or is aborted
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE; phase=0; remaining=0; timer=0;
//    busy=0; done=0; step_strobe=0. cmd_ready=1 from the first cycle after reset.
//  - States: IDLE, RUN, DONE. All registers are clocked; outputs decode from state and timer.
//  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready:
//    - steps==0: go to DONE. No strobe; phase unchanged.
//    - otherwise: latch dir, set remaining=cmd_steps, set timer=PERIOD-1, go to RUN.
//  - RUN: busy=1. Each cycle with timer!=0: timer decrements.
//    - timer==0: step_strobe=1. On that edge phase moves by ±1 mod 4,
//      remaining decrements, and timer reloads to PERIOD-1.
//    - If remaining==1 on that edge, go to DONE.
//  - DONE: done=1 and cmd_ready=0 for exactly one cycle, then return to IDLE.
//  - Timing: the first strobe is in the PERIOD-th cycle after the accept edge.
//    done is in the cycle after the last strobe.
//    Total from accept to done = steps*PERIOD + 1 cycles.
//  - abort: honoured only in RUN. Next state is DONE, and no strobe occurs that cycle
//    (abort beats a timer==0 step). remaining holds its value.
//    abort in IDLE or DONE is ignored.
//  - Back-to-back commands: the earliest next accept is the IDLE cycle following done.
//    A cmd_valid held through DONE is not consumed.
//  - Phase wrap: 3 +1 -> 0 and 0 -1 -> 3. Phase persists across commands.
//    Only rst clears phase.
//  - Reset mid-RUN: immediate return to the reset values above. No done pulse.
//  - Widths: remaining is unsigned STEP_W. The timer is 16 bits.
//    cmd_steps of all-ones is legal (2^STEP_W-1 steps).
//  - PERIOD==1: timer stays 0 and a strobe occurs every RUN cycle.
// STRUCTURE
//  - fsm_step_defs.vh (shared include): state encodings ST_IDLE=2'd0, ST_RUN=2'd1,
//    ST_DONE=2'd2; DIR_UP=1'b0, DIR_DOWN=1'b1.
//  - Sub-module phase_counter_m4_v (clk, rst, en, dir -> phase[1:0]):
//    mod-4 up/down counter with enable, synchronous active-low reset to 0.
//    Driven with en=step_strobe, dir=latched dir.
//  - Top level: FSM, PERIOD timer, remaining counter, handshake decode.
// TESTING
//  1. PERIOD=4; after reset, up with 3 steps -> strobes 4, 8, 12 cycles after accept;
//     phase 0->1->2->3; done at +13; busy low after.
//  2. From phase 0: down with 2 steps -> phase 3 then 2; remaining 2->1->0; one done pulse.
//  3. From phase 0: up with 5 steps -> phase 1,2,3,0,1 (wrap checked); done at +21.
//  4. steps=0 -> done in the cycle after accept; no strobe; phase unchanged; busy never high.
//  5. up with 4 steps, abort in the cycle after the first strobe -> remaining=3,
//     done next cycle, phase advanced exactly once.
//  6. Abort coincident with timer==0 -> no strobe; phase unchanged on that edge; done follows.
//  7. rst=0 mid-RUN -> phase=0, remaining=0, busy=0, no done; cmd_ready=1 after release.
//  8. cmd_valid held high across done -> second command accepted only in the IDLE cycle
//     after done; phase continues from its previous value.

Source files
------------

// File: rtl/fsm_step_sequencer_v_pkg.sv
// Shared definitions for the step sequencer: FSM state encodings, direction
// codes, timer width and the mod-4 phase step helper.
package fsm_step_sequencer_v_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int unsigned TIMER_W = 16;

    // Two-bit arithmetic wraps naturally: 3+1 -> 0, 0-1 -> 3.
    function automatic logic [1:0] phase_step(input logic [1:0] p, input logic dir);
        return (dir == DIR_DOWN) ? (p - 2'd1) : (p + 2'd1);
    endfunction

endpackage

// File: rtl/fsm_step_sequencer_v_phase_counter.sv
// phase_counter_m4_v: mod-4 up/down phase counter with enable.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-low reset, clears phase to 0
//   i_en   in   advance the phase on this edge
//   i_dir  in   0 = up, 1 = down
//   o_phase out current phase
module phase_counter_m4_v
    import fsm_step_sequencer_v_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_dir,
    output logic [1:0] o_phase
);

    logic [1:0] r_phase;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_phase <= 2'd0;
        end else if (i_en) begin
            r_phase <= phase_step(r_phase, i_dir);
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/fsm_step_sequencer_v.sv
// fsm_step_sequencer_v: command-driven sequencer for a mod-4 phase counter.
// Accepts (direction, step count) commands over valid/ready, steps the phase
// once every PERIOD clocks and pulses done when the move ends or is aborted.
// Ports:
//   clk, rst          clock / synchronous active-low reset
//   i_cmd_valid       command present
//   o_cmd_ready       command can be accepted (IDLE only)
//   i_cmd_dir         0 = up, 1 = down
//   i_cmd_steps       number of phase steps
//   i_abort           end the current move (RUN only)
//   o_phase           current phase
//   o_step_strobe     phase changes on the following edge
//   o_remaining       steps still to perform
//   o_busy            high in RUN
//   o_done            one-cycle pulse at end of move
module fsm_step_sequencer_v
    import fsm_step_sequencer_v_pkg::*;
#(
    parameter int unsigned STEP_W = 8,
    parameter int unsigned PERIOD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_dir,
    input  logic [STEP_W-1:0] i_cmd_steps,
    input  logic              i_abort,
    output logic [1:0]        o_phase,
    output logic              o_step_strobe,
    output logic [STEP_W-1:0] o_remaining,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [TIMER_W-1:0] TimerReload = TIMER_W'(PERIOD - 1);

    state_e              r_state, w_state_d;
    logic [TIMER_W-1:0]  r_timer, w_timer_d;
    logic [STEP_W-1:0]   r_remaining, w_remaining_d;
    logic                r_dir, w_dir_d;
    logic                w_strobe;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_remaining <= '0;
            r_dir       <= DIR_UP;
        end else begin
            r_state     <= w_state_d;
            r_timer     <= w_timer_d;
            r_remaining <= w_remaining_d;
            r_dir       <= w_dir_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_timer_d     = r_timer;
        w_remaining_d = r_remaining;
        w_dir_d       = r_dir;
        w_strobe      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    if (i_cmd_steps == '0) begin
                        w_state_d = ST_DONE;
                    end else begin
                        w_dir_d       = i_cmd_dir;
                        w_remaining_d = i_cmd_steps;
                        w_timer_d     = TimerReload;
                        w_state_d     = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Abort wins over a due step: no strobe, remaining held.
                if (i_abort) begin
                    w_state_d = ST_DONE;
                end else if (r_timer == '0) begin
                    w_strobe      = 1'b1;
                    w_remaining_d = r_remaining - STEP_W'(1);
                    w_timer_d     = TimerReload;
                    if (r_remaining == STEP_W'(1)) begin
                        w_state_d = ST_DONE;
                    end
                end else begin
                    w_timer_d = r_timer - TIMER_W'(1);
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    phase_counter_m4_v u_phase (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_strobe),
        .i_dir   (r_dir),
        .o_phase (o_phase)
    );

    assign o_cmd_ready   = (r_state == ST_IDLE);
    assign o_busy        = (r_state == ST_RUN);
    assign o_done        = (r_state == ST_DONE);
    assign o_step_strobe = w_strobe;
    assign o_remaining   = r_remaining;

endmodule

// File: tb/tb_fsm_step_sequencer_v.sv
// Directed self-checking bench for fsm_step_sequencer_v (STEP_W=8, PERIOD=4).
// Cycle k of a move is the k-th cycle after the accept edge.
module tb_fsm_step_sequencer_v;

    logic       clk;
    logic       rst;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic       i_cmd_dir;
    logic [7:0] i_cmd_steps;
    logic       i_abort;
    logic [1:0] o_phase;
    logic       o_step_strobe;
    logic [7:0] o_remaining;
    logic       o_busy;
    logic       o_done;

    int n_checks = 0;
    int n_errors = 0;

    // Per-move observations filled in by watch_move.
    logic [1:0] ph  [0:255];
    logic [7:0] rem [0:255];
    int strobe_cnt, first_strobe, last_strobe, busy_cnt, done_cyc, done_cnt;
    logic ready_at_done;

    fsm_step_sequencer_v #(
        .STEP_W (8),
        .PERIOD (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_dir     (i_cmd_dir),
        .i_cmd_steps   (i_cmd_steps),
        .i_abort       (i_abort),
        .o_phase       (o_phase),
        .o_step_strobe (o_step_strobe),
        .o_remaining   (o_remaining),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_dir   = 1'b0;
        i_cmd_steps = 8'd0;
        i_abort     = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    // Present a command and let the accept edge pass.
    task automatic accept(input logic dir, input logic [7:0] steps, input logic hold);
        i_cmd_valid = 1'b1;
        i_cmd_dir   = dir;
        i_cmd_steps = steps;
        tick();
        if (!hold) i_cmd_valid = 1'b0;
    endtask

    // Observe cycles 1.. of a move until done (bounded); abort in cycle abort_at.
    task automatic watch_move(input int abort_at);
        strobe_cnt = 0; first_strobe = 0; last_strobe = 0;
        busy_cnt = 0; done_cyc = 0; done_cnt = 0; ready_at_done = 1'b1;
        for (int k = 1; k < 200; k++) begin
            i_abort = (k == abort_at);
            #1;
            ph[k]  = o_phase;
            rem[k] = o_remaining;
            if (o_step_strobe) begin
                strobe_cnt++;
                if (first_strobe == 0) first_strobe = k;
                last_strobe = k;
            end
            if (o_busy) busy_cnt++;
            if (o_done) begin
                done_cnt++;
                done_cyc = k;
                ready_at_done = o_cmd_ready;
            end
            tick();
            i_abort = 1'b0;
            if (done_cyc != 0) break;
        end
    endtask

    initial begin
        do_reset();
        // Reset state
        check_val("rst_phase", o_phase, 0);
        check_val("rst_remaining", o_remaining, 0);
        check_val("rst_busy", o_busy, 0);
        check_val("rst_done", o_done, 0);
        check_val("rst_strobe", o_step_strobe, 0);
        check_val("rst_ready", o_cmd_ready, 1);

        // 1: up 3 steps
        accept(1'b0, 8'd3, 1'b0);
        watch_move(0);
        check_val("t1_first_strobe", first_strobe, 4);
        check_val("t1_last_strobe", last_strobe, 12);
        check_val("t1_strobes", strobe_cnt, 3);
        check_val("t1_ph5", ph[5], 1);
        check_val("t1_ph9", ph[9], 2);
        check_val("t1_ph13", ph[13], 3);
        check_val("t1_done_cyc", done_cyc, 13);
        check_val("t1_busy_after", o_busy, 0);
        check_val("t1_ready_after", o_cmd_ready, 1);

        // 2: down 2 steps from 0
        do_reset();
        accept(1'b1, 8'd2, 1'b0);
        watch_move(0);
        check_val("t2_rem1", rem[1], 2);
        check_val("t2_rem5", rem[5], 1);
        check_val("t2_rem9", rem[9], 0);
        check_val("t2_ph5", ph[5], 3);
        check_val("t2_ph9", ph[9], 2);
        check_val("t2_done_cyc", done_cyc, 9);
        check_val("t2_done_cnt", done_cnt, 1);
        check_val("t2_done_gone", o_done, 0);

        // 3: up 5 steps from 0, wraps
        do_reset();
        accept(1'b0, 8'd5, 1'b0);
        watch_move(0);
        check_val("t3_ph5", ph[5], 1);
        check_val("t3_ph13", ph[13], 3);
        check_val("t3_ph17", ph[17], 0);
        check_val("t3_ph21", ph[21], 1);
        check_val("t3_done_cyc", done_cyc, 21);

        // 4: zero steps, phase stays at 1
        accept(1'b0, 8'd0, 1'b0);
        watch_move(0);
        check_val("t4_done_cyc", done_cyc, 1);
        check_val("t4_strobes", strobe_cnt, 0);
        check_val("t4_busy", busy_cnt, 0);
        check_val("t4_phase", ph[1], 1);

        // 5: abort in the cycle after the first strobe
        do_reset();
        accept(1'b0, 8'd4, 1'b0);
        watch_move(5);
        check_val("t5_strobes", strobe_cnt, 1);
        check_val("t5_done_cyc", done_cyc, 6);
        check_val("t5_rem", rem[6], 3);
        check_val("t5_phase", ph[6], 1);

        // 6: abort coincident with timer==0
        do_reset();
        accept(1'b0, 8'd4, 1'b0);
        watch_move(4);
        check_val("t6_strobes", strobe_cnt, 0);
        check_val("t6_done_cyc", done_cyc, 5);
        check_val("t6_phase", ph[5], 0);
        check_val("t6_rem", rem[5], 4);

        // 7: reset mid-RUN
        do_reset();
        accept(1'b0, 8'd4, 1'b0);
        repeat (4) tick();
        check_val("t7_pre_phase", o_phase, 1);
        check_val("t7_pre_busy", o_busy, 1);
        rst = 1'b0;
        tick();
        check_val("t7_phase", o_phase, 0);
        check_val("t7_rem", o_remaining, 0);
        check_val("t7_busy", o_busy, 0);
        check_val("t7_done", o_done, 0);
        rst = 1'b1;
        tick();
        check_val("t7_ready", o_cmd_ready, 1);
        check_val("t7_done_after", o_done, 0);

        // 8: cmd_valid held across done
        do_reset();
        accept(1'b0, 8'd2, 1'b1);
        watch_move(0);
        check_val("t8_done_cyc", done_cyc, 9);
        check_val("t8_ready_in_done", ready_at_done, 0);
        check_val("t8_idle_ready", o_cmd_ready, 1);
        check_val("t8_idle_busy", o_busy, 0);
        tick();
        i_cmd_valid = 1'b0;
        check_val("t8_busy2", o_busy, 1);
        check_val("t8_rem2", o_remaining, 2);
        watch_move(0);
        check_val("t8_ph5", ph[5], 3);
        check_val("t8_done2_cyc", done_cyc, 9);
        check_val("t8_phase_end", ph[9], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
